// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: PC unit, instruction memory, hazard inputs and IF/ID outputs.
// When FETCH_PERF_EN is defined the bundle also carries the fetch/miss counters.
interface fetch_unit_if;
  logic [31:0] pcout;
  logic        pcenable;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        stall;
  logic        flush;
  logic        halt;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_npc;
  logic        ifid_valid;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count;
  logic [31:0] miss_count;
`endif

  // Fetch unit side
  modport master (
    input  pcout, ihit, imemload, stall, flush, halt,
    output pcenable, imemREN, imemaddr, ifid_instr, ifid_npc, ifid_valid
`ifdef FETCH_PERF_EN
    , output fetch_count, miss_count
`endif
  );

  // Environment side (PC unit, memory, hazard unit, decode)
  modport slave (
    output pcout, ihit, imemload, stall, flush, halt,
    input  pcenable, imemREN, imemaddr, ifid_instr, ifid_npc, ifid_valid
`ifdef FETCH_PERF_EN
    , input fetch_count, miss_count
`endif
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch controller feeding the IF/ID register.
// States: FETCH (reading at pcout), HOLD (returned word parked while decode stalls),
// DRAIN (waiting out a read orphaned by a flush), HALTED (sticky until reset).
// Optional feature macro: FETCH_PERF_EN adds fetch_count / miss_count counters.
module fetch_unit (
  input  logic         CLK,
  input  logic         nRST,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {FETCH, HOLD, DRAIN, HALTED} state_t;

  state_t      state_q, state_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_npc_q, ifid_npc_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] hold_npc_q, hold_npc_d;
  logic [31:0] drain_addr_q, drain_addr_d;
  logic        halt_pend_q, halt_pend_d;

  logic        pcen_c;
  logic        ren_c;
  logic [31:0] addr_c;
  logic [31:0] npc_c;

  // PC+4 wraps naturally in 32 bits
  assign npc_c = bus.pcout + 32'd4;

  // State and data registers; reset clears IF/ID, hold buffer and drain address
  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      state_q      <= FETCH;
      ifid_instr_q <= 32'd0;
      ifid_npc_q   <= 32'd0;
      ifid_valid_q <= 1'b0;
      hold_instr_q <= 32'd0;
      hold_npc_q   <= 32'd0;
      drain_addr_q <= 32'd0;
      halt_pend_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_npc_q   <= ifid_npc_d;
      ifid_valid_q <= ifid_valid_d;
      hold_instr_q <= hold_instr_d;
      hold_npc_q   <= hold_npc_d;
      drain_addr_q <= drain_addr_d;
      halt_pend_q  <= halt_pend_d;
    end
  end

  // Next-state and memory/PC handshake; priority is flush > stall > normal
  always_comb begin
    state_d      = state_q;
    ifid_instr_d = ifid_instr_q;
    ifid_npc_d   = ifid_npc_q;
    ifid_valid_d = ifid_valid_q;
    hold_instr_d = hold_instr_q;
    hold_npc_d   = hold_npc_q;
    drain_addr_d = drain_addr_q;
    halt_pend_d  = halt_pend_q;
    pcen_c       = 1'b0;
    ren_c        = 1'b0;
    addr_c       = 32'd0;

    case (state_q)
      FETCH: begin
        ren_c  = 1'b1;
        addr_c = bus.pcout;
        if (bus.flush) begin
          pcen_c       = 1'b1;
          ifid_instr_d = 32'd0;
          ifid_npc_d   = 32'd0;
          ifid_valid_d = 1'b0;
          hold_instr_d = 32'd0;
          hold_npc_d   = 32'd0;
          halt_pend_d  = 1'b0;
          if (!bus.ihit) begin
            // The read at pcout is still in flight; its data must be thrown away
            drain_addr_d = bus.pcout;
            state_d      = DRAIN;
          end
        end else if (bus.ihit) begin
          pcen_c = 1'b1;
          if (bus.stall) begin
            hold_instr_d = bus.imemload;
            hold_npc_d   = npc_c;
            halt_pend_d  = bus.halt;
            state_d      = HOLD;
          end else begin
            ifid_instr_d = bus.imemload;
            ifid_npc_d   = npc_c;
            ifid_valid_d = 1'b1;
            if (bus.halt) state_d = HALTED;
          end
        end else if (!bus.stall) begin
          ifid_instr_d = 32'd0;
          ifid_npc_d   = 32'd0;
          ifid_valid_d = 1'b0;
        end
      end

      HOLD: begin
        if (bus.flush) begin
          pcen_c       = 1'b1;
          ifid_instr_d = 32'd0;
          ifid_npc_d   = 32'd0;
          ifid_valid_d = 1'b0;
          hold_instr_d = 32'd0;
          hold_npc_d   = 32'd0;
          halt_pend_d  = 1'b0;
          state_d      = FETCH;
        end else if (!bus.stall) begin
          ifid_instr_d = hold_instr_q;
          ifid_npc_d   = hold_npc_q;
          ifid_valid_d = 1'b1;
          hold_instr_d = 32'd0;
          hold_npc_d   = 32'd0;
          halt_pend_d  = 1'b0;
          state_d      = halt_pend_q ? HALTED : FETCH;
        end
      end

      DRAIN: begin
        ren_c  = 1'b1;
        addr_c = drain_addr_q;
        if (bus.flush) begin
          pcen_c       = 1'b1;
          ifid_instr_d = 32'd0;
          ifid_npc_d   = 32'd0;
          ifid_valid_d = 1'b0;
          hold_instr_d = 32'd0;
          hold_npc_d   = 32'd0;
          halt_pend_d  = 1'b0;
        end else begin
          if (bus.ihit) state_d = FETCH;
          if (!bus.stall) begin
            ifid_instr_d = 32'd0;
            ifid_npc_d   = 32'd0;
            ifid_valid_d = 1'b0;
          end
        end
      end

      HALTED: begin
        if (bus.flush || !bus.stall) begin
          ifid_instr_d = 32'd0;
          ifid_npc_d   = 32'd0;
          ifid_valid_d = 1'b0;
        end
      end

      default: state_d = FETCH;
    endcase
  end

  assign bus.pcenable   = nRST ? 1'b0  : pcen_c;
  assign bus.imemREN    = nRST ? 1'b0  : ren_c;
  assign bus.imemaddr   = nRST ? 32'd0 : addr_c;
  assign bus.ifid_instr = ifid_instr_q;
  assign bus.ifid_npc   = ifid_npc_q;
  assign bus.ifid_valid = ifid_valid_q;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] miss_count_q, miss_count_d;
  logic        accept_c;
  logic        miss_c;

  // Count words when they land in IF/ID, so words later flushed from hold never count
  always_comb begin
    accept_c = 1'b0;
    miss_c   = 1'b0;
    if (state_q == FETCH && bus.ihit && !bus.flush && !bus.stall) accept_c = 1'b1;
    if (state_q == HOLD && !bus.flush && !bus.stall) accept_c = 1'b1;
    if ((state_q == FETCH || state_q == DRAIN) && !bus.ihit) miss_c = 1'b1;
    fetch_count_d = fetch_count_q + {31'd0, accept_c};
    miss_count_d  = miss_count_q + {31'd0, miss_c};
  end

  // Wrapping performance counters
  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      fetch_count_q <= 32'd0;
      miss_count_q  <= 32'd0;
    end else begin
      fetch_count_q <= fetch_count_d;
      miss_count_q  <= miss_count_d;
    end
  end

  assign bus.fetch_count = fetch_count_q;
  assign bus.miss_count  = miss_count_q;
`endif

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch controller between the PC unit and the IF/ID pipeline register. Issues instruction-memory reads at the current PC and accepts the returned word into the IF/ID register. Pulses `pcenable` so the PC unit advances or takes a redirect, and absorbs decode stalls, control-flow flushes and halt. A one-entry hold buffer keeps a returned instruction when decode is stalled, so an `ihit` is never lost.

## Interface
Parameters: none.
- `CLK` in 1: clock, all state updates on posedge.
- `nRST` in 1: asynchronous, active-high reset (1 = reset asserted).
- `pcout` in 32: current PC from the PC unit.
- `pcenable` out 1: combinational; PC unit loads its next PC at the coming edge.
- `imemREN` out 1: instruction read request.
- `imemaddr` out 32: read address; stable while `imemREN`=1 and `ihit`=0.
- `ihit` in 1: read data valid this cycle.
- `imemload` in 32: instruction word, valid with `ihit`.
- `stall` in 1: hazard unit hold of IF/ID.
- `flush` in 1: redirect taken downstream; PC mux already selects the target.
- `halt` in 1: stop fetching (sticky until reset).
- `ifid_instr` out 32: IF/ID instruction (0 = nop bubble).
- `ifid_npc` out 32: PC+4 of `ifid_instr`.
- `ifid_valid` out 1: IF/ID holds a real instruction.

## Operation
- States: FETCH, HOLD, DRAIN, HALTED. Reset state FETCH. While reset is asserted, all outputs are 0, and hold buffer and drain address are cleared.
- Priority each cycle: flush > stall > normal.
- FETCH: `imemREN`=1, `imemaddr`=`pcout`.
  - `ihit` & !`stall`: IF/ID <= {`imemload`, `pcout`+4, valid=1}; `pcenable`=1.
  - `ihit` & `stall`: hold <= {`imemload`, `pcout`+4}; `pcenable`=1; IF/ID unchanged; go HOLD.
  - !`ihit` & !`stall`: IF/ID <= bubble (instr 0, npc 0, valid 0).
  - !`ihit` & `stall`: IF/ID unchanged.
  - `halt`=1 on an `ihit` cycle: the word is accepted as above, then go HALTED. If the word goes to the hold buffer, go HOLD, then HALTED after release.
- HOLD: `imemREN`=0, `pcenable`=0. When `stall` drops: IF/ID <= hold, valid=1; go FETCH.
- DRAIN: `imemREN`=1, `imemaddr`=drain address. On `ihit`, discard the data and go FETCH.
- HALTED: `imemREN`=0, `pcenable`=0. IF/ID <= bubble when !`stall`. Exit only by reset.
- flush in any state except HALTED:
  - IF/ID <= bubble and hold buffer discarded.
  - `pcenable`=1 so the PC loads the redirect target.
  - A same-cycle `ihit` is discarded.
  - From FETCH with `ihit`=0: drain address <= `pcout`; go DRAIN.
  - Otherwise go FETCH. In DRAIN, stay DRAIN and keep the drain address.
- flush in HALTED: IF/ID <= bubble only.
- `pcout`+4 wraps modulo 2^32 (0xFFFFFFFC -> 0x00000000).

## Timing
- `pcenable`, `imemREN`, `imemaddr` are combinational from state, `ihit`, `flush`, `pcout`.
- `ihit` may arrive in the same cycle as `imemREN`. Latency is 0 cycles from `ihit` to IF/ID capture at the next edge.
- Sustained throughput is 1 instruction per cycle with continuous `ihit` and no stall.
- `pcout` changes only after a `pcenable` edge, so the FETCH address is stable across a multi-cycle miss.
- Reset asserted mid-miss or mid-HOLD: immediate return to FETCH with outputs 0. The stale `ihit` after reset is accepted as a fetch at the reset PC.

## Configuration
- `FETCH_PERF_EN` defined:
  - Adds outputs `fetch_count` out 32, incremented per instruction accepted into IF/ID or hold and not discarded.
  - Adds `miss_count` out 32, incremented per FETCH/DRAIN cycle with `imemREN`=1 and `ihit`=0.
  - Both reset to 0 and wrap.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

## Test plan
- Reset, then `pcout`=0, `ihit`=1 for 3 cycles with words A,B,C. Required: `pcenable` high each cycle; IF/ID shows A/4, B/8, C/12 with valid=1.
- `ihit`=0 for 3 cycles at `pcout`=0x40, then `ihit`. Required: `imemaddr`=0x40 throughout; IF/ID bubbles; then instr/0x44.
- `stall`=1 with `ihit` word D at 0x10, stall held 2 more cycles. Required: `imemREN`=0 in HOLD; IF/ID unchanged; on release IF/ID=D/0x14 valid.
- `flush` during a miss at 0x20. Required: `pcenable`=1; DRAIN keeps `imemaddr`=0x20; the returned word is discarded; the next fetch is at the redirect target.
- `flush` and `stall` together with `ihit`. Required: IF/ID bubble, hold empty, `pcenable`=1.
- `halt`=1 on `ihit` of word E at 0x30. Required: E accepted; then `imemREN`=0 and valid=0 forever until reset. With `FETCH_PERF_EN`, `fetch_count` is unchanged after E.
